// File: rtl/apu_pkg.sv
// Shared types and widths for the APU sample-fetch interface.
package apu_pkg;

  localparam int APU_ADDR_W = 29;
  localparam int APU_DATA_W = 64;
  localparam int APU_BYTES  = APU_DATA_W / 8;

  typedef logic [APU_DATA_W-1:0] apu_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    ACK  = 2'd2
  } srv_state_t;

endpackage

// File: rtl/apu_sample_ram.sv
// Simple dual-port sample RAM: one byte-enabled write port, one registered read port.
// Read-during-write to the same word returns the old contents.
module apu_sample_ram
  import apu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  apu_word_t             wdata,
  input  logic [APU_BYTES-1:0]  byteena,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output apu_word_t             rdata
);

  // One narrow array per byte lane keeps the byte-enable inference simple.
  for (genvar b = 0; b < APU_BYTES; b++) begin : g_lane
    logic [7:0] mem [0:2**DEPTH_LOG2-1];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (we && byteena[b]) mem[waddr] <= wdata[8*b +: 8];
      if (re) q <= mem[raddr];
    end

    assign rdata[8*b +: 8] = q;
  end

endmodule

// File: rtl/apu_sample_server.sv
// APU sample-fetch responder backed by an HPS-written sample RAM.
// Optional one-word speculative prefetch enabled by APU_SAMPLE_PREFETCH_EN.
module apu_sample_server
  import apu_pkg::*;
#(
  parameter int                    DEPTH_LOG2 = 12,
  parameter logic [APU_ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_en,
  input  logic [APU_ADDR_W-1:0] mem_addr,
  output apu_word_t             mem_data,
  output logic                  mem_ack,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic                  wr_en,
  input  apu_word_t             wr_data,
  input  logic [APU_BYTES-1:0]  wr_byteena,
  output logic                  busy
);

  // Range math is one bit wider so BASE_ADDR + depth can never wrap.
  localparam logic [APU_ADDR_W:0] BASE_X = {1'b0, BASE_ADDR};
  localparam logic [APU_ADDR_W:0] LIM_X  = BASE_X + ((APU_ADDR_W+1)'(1) << DEPTH_LOG2);

  function automatic logic is_local(input logic [APU_ADDR_W:0] a);
    return (a >= BASE_X) && (a < LIM_X);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] to_idx(input logic [APU_ADDR_W:0] a);
    return DEPTH_LOG2'(a - BASE_X);
  endfunction

  srv_state_t            state, state_nxt;
  logic                  loc_q;
  logic                  req_loc;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_addr;
  apu_word_t             rd_data;
  logic                  we;

  logic                  pf_hit;
  logic                  pf_issue;
  logic [DEPTH_LOG2-1:0] pf_idx;
  apu_word_t             pf_data;

  assign req_loc = is_local({1'b0, mem_addr});
  assign req_idx = to_idx({1'b0, mem_addr});
  assign we      = wr_en & ~rst;
  assign mem_ack = (state == ACK);
  assign busy    = (state != IDLE);

`ifdef APU_SAMPLE_PREFETCH_EN
  logic                  pf_vld, pf_pend, pf_fly, pf_wr_hit;
  logic [APU_ADDR_W-1:0] addr_q, pf_addr;
  logic [APU_ADDR_W:0]   nxt_x;

  assign nxt_x     = {1'b0, addr_q} + 1'b1;
  assign pf_idx    = to_idx({1'b0, pf_addr});
  assign pf_wr_hit = we && (wr_addr == pf_idx);
  // A read still in flight cannot be trusted as a hit; it is served as a miss.
  assign pf_hit    = pf_vld && !pf_fly && (mem_addr == pf_addr);
  // Speculative read only borrows the port in idle cycles with no request.
  assign pf_issue  = (state == IDLE) && !mem_read_en && pf_pend && !pf_wr_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      pf_addr <= '0;
      pf_data <= '0;
      pf_vld  <= 1'b0;
      pf_pend <= 1'b0;
      pf_fly  <= 1'b0;
    end else begin
      pf_fly <= pf_issue;
      if (state == IDLE && mem_read_en) addr_q <= mem_addr;
      if (pf_issue) pf_pend <= 1'b0;
      if (pf_fly) begin
        if (pf_wr_hit) pf_pend <= 1'b1;
        else begin
          pf_data <= rd_data;
          pf_vld  <= 1'b1;
        end
      end
      if (pf_vld && pf_wr_hit) pf_vld <= 1'b0;
      if (state == ACK && loc_q) begin
        pf_vld  <= 1'b0;
        pf_pend <= is_local(nxt_x);
        pf_addr <= nxt_x[APU_ADDR_W-1:0];
      end
    end
  end
`else
  assign pf_hit   = 1'b0;
  assign pf_issue = 1'b0;
  assign pf_idx   = '0;
  assign pf_data  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = req_idx;
    unique case (state)
      IDLE: begin
        if (mem_read_en) begin
          if (pf_hit) state_nxt = ACK;
          else begin
            state_nxt = RD;
            rd_en     = req_loc;
          end
        end else if (pf_issue) begin
          rd_en   = 1'b1;
          rd_addr = pf_idx;
        end
      end
      RD:      state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_data <= '0;
      loc_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (mem_read_en) begin
          loc_q <= req_loc;
          if (pf_hit) mem_data <= pf_data;
        end
        RD:      mem_data <= loc_q ? rd_data : '0;
        default: mem_data <= '0;
      endcase
    end
  end

  apu_sample_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .byteena (wr_byteena),
    .re      (rd_en & ~rst),
    .raddr   (rd_addr),
    .rdata   (rd_data)
  );

endmodule

// File: tb/tb_apu_sample_server.sv
// Directed bench for apu_sample_server; latency expectations follow APU_SAMPLE_PREFETCH_EN.
module tb_apu_sample_server;
  import apu_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_read_en;
  logic [28:0]     mem_addr;
  apu_word_t       mem_data;
  logic            mem_ack;
  logic [11:0]     wr_addr;
  logic            wr_en;
  apu_word_t       wr_data;
  logic [7:0]      wr_byteena;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apu_sample_server #(.DEPTH_LOG2(12), .BASE_ADDR(29'h0)) dut (
    .clk(clk), .rst(rst), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack), .wr_addr(wr_addr), .wr_en(wr_en),
    .wr_data(wr_data), .wr_byteena(wr_byteena), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic wr(input logic [11:0] a, input logic [63:0] d, input logic [7:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_byteena = be;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Any write the caller has set up lands in the same cycle as the request.
  task automatic rd(input string tag, input logic [28:0] a, input logic [63:0] exp, input int exp_lat);
    int lat;
    mem_read_en = 1'b1; mem_addr = a; lat = 0;
    do begin
      @(negedge clk);
      wr_en = 1'b0;
      lat++;
      if (lat == 1 && !mem_ack) chk({tag, "_busy"}, 64'(busy), 64'd1);
    end while (!mem_ack && lat < 8);
    mem_read_en = 1'b0;
    chk({tag, "_ack"}, 64'(mem_ack), 64'd1);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_data"}, mem_data, exp);
    idle(3);
  endtask

`ifdef APU_SAMPLE_PREFETCH_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 2;
`endif

  initial begin
    rst = 1'b1; mem_read_en = 1'b1; mem_addr = 29'h2000;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_byteena = '0;

    // reset held two cycles with a request pending
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ack", 64'(mem_ack), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_data", mem_data, 64'd0);
    end
    rst = 1'b0;
    rd("first_after_rst", 29'h2000, 64'd0, 2);

    // full write then read
    wr(12'd5, 64'h0123_4567_89AB_CDEF, 8'hFF);
    rd("full_wr", 29'd5, 64'h0123_4567_89AB_CDEF, 2);

    // partial byte-enable write
    wr(12'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    rd("byteena", 29'd5, 64'h0123_4567_FFFF_FFFF, 2);

    // range boundaries
    rd("oor_1000", 29'h1000, 64'd0, 2);
    wr(12'hFFF, 64'hDEAD_BEEF_0000_0FFF, 8'hFF);
    rd("top_word", 29'h0FFF, 64'hDEAD_BEEF_0000_0FFF, 2);
    rd("oor_high", 29'h1FFF_FFFF, 64'd0, 2);

    // same-cycle read and write of word 7
    wr(12'd7, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
    wr_en = 1'b1; wr_addr = 12'd7; wr_data = 64'hBBBB_BBBB_BBBB_BBBB; wr_byteena = 8'hFF;
    rd("rdw_old", 29'd7, 64'hAAAA_AAAA_AAAA_AAAA, 2);
    rd("rdw_new", 29'd7, 64'hBBBB_BBBB_BBBB_BBBB, 2);

    // sequential reads and write invalidation of the next word
    wr(12'd10, 64'h1010_1010_1010_1010, 8'hFF);
    wr(12'd11, 64'h1111_1111_1111_1111, 8'hFF);
    rd("seq_10", 29'd10, 64'h1010_1010_1010_1010, 2);
    rd("seq_11", 29'd11, 64'h1111_1111_1111_1111, HIT_LAT);
    rd("seq_10b", 29'd10, 64'h1010_1010_1010_1010, 2);
    wr(12'd11, 64'h2222_3333_4444_5555, 8'hFF);
    rd("inval_11", 29'd11, 64'h2222_3333_4444_5555, 2);

    // reset in mid-transaction, write in the reset cycle is dropped
    wr(12'd9, 64'h0000_0000_0000_0111, 8'hFF);
    mem_read_en = 1'b1; mem_addr = 29'd9;
    @(negedge clk);
    mem_read_en = 1'b0; rst = 1'b1;
    wr_en = 1'b1; wr_addr = 12'd9; wr_data = 64'h222; wr_byteena = 8'hFF;
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_noack", 64'(mem_ack), 64'd0);
      @(negedge clk);
    end
    rd("rst_wr_drop", 29'd9, 64'h0000_0000_0000_0111, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
